// File: rtl/track_drive_if.sv
// Steering-code input and wheel-drive output bundle for the track drive stage.
// Signal direction is named from the drive stage: i_* flow into it, o_* out of it.
interface track_drive_if;
   logic       i_enable;     // run request; low forces IDLE
   logic [1:0] i_state;      // steering code: 11 straight, 10 left, 01 right, 00 lost
   logic       o_left_pwm;   // left wheel PWM, registered
   logic       o_right_pwm;  // right wheel PWM, registered
   logic       o_left_dir;   // 1 = forward, 0 = reverse
   logic       o_right_dir;  // 1 = forward, 0 = reverse
   logic [2:0] o_mode;       // driving mode, also the FSM state for observation

   // master: the upstream tracker / bench that supplies the steering code
   modport master (
      output i_enable, i_state,
      input  o_left_pwm, o_right_pwm, o_left_dir, o_right_dir, o_mode
   );

   // slave: the drive stage itself
   modport slave (
      input  i_enable, i_state,
      output o_left_pwm, o_right_pwm, o_left_dir, o_right_dir, o_mode
   );
endinterface

// File: rtl/track_drive.sv
// Line-following drive stage: debounces the steering code, selects a driving
// mode (with lost-line search and timeout stop), ramps per-wheel duty towards
// mode targets once per PWM period and generates registered PWM + direction.
// A wheel only reverses after its duty has ramped all the way down to zero.
// There is no valid/ready handshake: i_state is a level sampled every clock,
// and every output is a registered level that is valid on every cycle.
// o_mode is the FSM state register itself, so the state is always observable.
module track_drive #(
   parameter int PWM_PERIOD     = 1024,
   parameter int CRUISE_DUTY    = 768,
   parameter int TURN_FAST      = 768,
   parameter int TURN_SLOW      = 256,
   parameter int SEARCH_DUTY    = 512,
   parameter int RAMP_STEP      = 16,
   parameter int FILTER_LEN     = 4,
   parameter int SEARCH_TIMEOUT = 50_000_000
) (
   input logic          i_clk,
   input logic          i_reset,
   track_drive_if.slave bus
);

   // Duty must be able to hold PWM_PERIOD itself (constant-high), hence +1 bit.
   localparam int DW = $clog2(PWM_PERIOD) + 1;
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int SW = $clog2(SEARCH_TIMEOUT + 1);

   // Targets above the period are meaningless; clamp them to constant-high.
   localparam int CRUISE_C = (CRUISE_DUTY > PWM_PERIOD) ? PWM_PERIOD : CRUISE_DUTY;
   localparam int FAST_C   = (TURN_FAST   > PWM_PERIOD) ? PWM_PERIOD : TURN_FAST;
   localparam int SLOW_C   = (TURN_SLOW   > PWM_PERIOD) ? PWM_PERIOD : TURN_SLOW;
   localparam int SEARCH_C = (SEARCH_DUTY > PWM_PERIOD) ? PWM_PERIOD : SEARCH_DUTY;
   localparam int STEP_C   = (RAMP_STEP   > PWM_PERIOD) ? PWM_PERIOD : RAMP_STEP;

   localparam logic [DW-1:0] CRUISE_D = DW'(CRUISE_C);
   localparam logic [DW-1:0] FAST_D   = DW'(FAST_C);
   localparam logic [DW-1:0] SLOW_D   = DW'(SLOW_C);
   localparam logic [DW-1:0] SEARCH_D = DW'(SEARCH_C);
   localparam logic [DW-1:0] STEP_D   = DW'(STEP_C);
   localparam logic [DW-1:0] PWM_LAST = DW'(PWM_PERIOD - 1);
   localparam logic [FW:0]   FILT_ACCEPT = (FW + 1)'(FILTER_LEN);
   localparam logic [SW-1:0] SEARCH_LAST = SW'(SEARCH_TIMEOUT - 1);

   typedef enum logic [2:0] {
      M_IDLE     = 3'd0,
      M_STRAIGHT = 3'd1,
      M_LEFT     = 3'd2,
      M_RIGHT    = 3'd3,
      M_SEARCH   = 3'd4,
      M_STOP     = 3'd5
   } mode_t;

   // Move cur toward tgt by at most one ramp step without overshooting.
   function automatic logic [DW-1:0] ramp_toward(input logic [DW-1:0] cur,
                                                 input logic [DW-1:0] tgt);
      logic [DW:0]   up;
      logic [DW-1:0] res;
      up  = {1'b0, cur} + {1'b0, STEP_D};
      res = cur;
      if (cur < tgt)
         res = (up > {1'b0, tgt}) ? tgt : up[DW-1:0];
      else if (cur > tgt)
         res = ((cur - tgt) > STEP_D) ? (cur - STEP_D) : tgt;
      return res;
   endfunction

   logic [1:0]    r_filt_last;
   logic [FW-1:0] r_filt_run;
   logic [1:0]    r_filt;
   logic [FW:0]   w_filt_run;

   mode_t         r_mode;
   mode_t         w_mode_next;
   logic [SW-1:0] r_search_cnt;
   logic          w_timeout;
   logic          r_last_left;

   logic [DW-1:0] r_cnt;
   logic [DW-1:0] r_duty_l, r_duty_r;
   logic          r_dir_l, r_dir_r;
   logic          r_pwm_l, r_pwm_r;
   logic [DW-1:0] w_tgt_l, w_tgt_r;
   logic          w_want_l, w_want_r;
   logic [DW-1:0] w_duty_l_nx, w_duty_r_nx;
   logic          w_dir_l_nx, w_dir_r_nx;

   // Length of the current run of identical samples, including this edge.
   always_comb begin
      w_filt_run = {1'b0, r_filt_run} + (FW + 1)'(1);
      if (bus.i_state != r_filt_last)
         w_filt_run = (FW + 1)'(1);
   end

   // Debounce: accept a code on the FILTER_LEN-th consecutive identical sample.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_filt_last <= 2'b00;
         r_filt_run  <= '0;
         r_filt      <= 2'b00;
      end else begin
         r_filt_last <= bus.i_state;
         if (w_filt_run >= FILT_ACCEPT) begin
            r_filt_run <= FW'(FILTER_LEN);
            r_filt     <= bus.i_state;
         end else begin
            r_filt_run <= w_filt_run[FW-1:0];
         end
      end
   end

   assign w_timeout = (r_search_cnt == SEARCH_LAST);

   // Mode selection: enable first, then a valid steering code, then search/stop.
   always_comb begin
      w_mode_next = r_mode;
      if (!bus.i_enable) begin
         w_mode_next = M_IDLE;
      end else begin
         case (r_filt)
            2'b11:   w_mode_next = M_STRAIGHT;
            2'b10:   w_mode_next = M_LEFT;
            2'b01:   w_mode_next = M_RIGHT;
            default: begin
               case (r_mode)
                  M_SEARCH: w_mode_next = w_timeout ? M_STOP : M_SEARCH;
                  M_STOP:   w_mode_next = M_STOP;
                  default:  w_mode_next = M_SEARCH;
               endcase
            end
         endcase
      end
   end

   // Mode register, search dwell counter (zero whenever not staying in SEARCH)
   // and memory of the last turn direction for the pivot search.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_mode       <= M_IDLE;
         r_search_cnt <= '0;
         r_last_left  <= 1'b1;
      end else begin
         r_mode <= w_mode_next;
         if (w_mode_next == M_SEARCH && r_mode == M_SEARCH)
            r_search_cnt <= r_search_cnt + SW'(1);
         else
            r_search_cnt <= '0;
         if (w_mode_next == M_LEFT)
            r_last_left <= 1'b1;
         else if (w_mode_next == M_RIGHT)
            r_last_left <= 1'b0;
      end
   end

   // Per-mode duty targets and wanted wheel directions.
   always_comb begin
      w_tgt_l  = '0;
      w_tgt_r  = '0;
      w_want_l = 1'b1;
      w_want_r = 1'b1;
      case (r_mode)
         M_STRAIGHT: begin
            w_tgt_l = CRUISE_D;
            w_tgt_r = CRUISE_D;
         end
         M_LEFT: begin
            w_tgt_l = SLOW_D;
            w_tgt_r = FAST_D;
         end
         M_RIGHT: begin
            w_tgt_l = FAST_D;
            w_tgt_r = SLOW_D;
         end
         M_SEARCH: begin
            w_tgt_l  = SEARCH_D;
            w_tgt_r  = SEARCH_D;
            w_want_l = ~r_last_left;
            w_want_r = r_last_left;
         end
         default: begin
            w_tgt_l = '0;
            w_tgt_r = '0;
         end
      endcase
   end

   // Wrap-time wheel update: drain duty before reversing, otherwise ramp to target.
   always_comb begin
      w_duty_l_nx = r_duty_l;
      w_dir_l_nx  = r_dir_l;
      w_duty_r_nx = r_duty_r;
      w_dir_r_nx  = r_dir_r;
      if (w_want_l != r_dir_l) begin
         if (r_duty_l == '0) w_dir_l_nx = w_want_l;
         else                w_duty_l_nx = ramp_toward(r_duty_l, '0);
      end else begin
         w_duty_l_nx = ramp_toward(r_duty_l, w_tgt_l);
      end
      if (w_want_r != r_dir_r) begin
         if (r_duty_r == '0) w_dir_r_nx = w_want_r;
         else                w_duty_r_nx = ramp_toward(r_duty_r, '0);
      end else begin
         w_duty_r_nx = ramp_toward(r_duty_r, w_tgt_r);
      end
   end

   // PWM counter, duty/direction update at wrap only, registered PWM compare.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt    <= '0;
         r_duty_l <= '0;
         r_duty_r <= '0;
         r_dir_l  <= 1'b1;
         r_dir_r  <= 1'b1;
         r_pwm_l  <= 1'b0;
         r_pwm_r  <= 1'b0;
      end else begin
         r_pwm_l <= (r_cnt < r_duty_l);
         r_pwm_r <= (r_cnt < r_duty_r);
         if (r_cnt == PWM_LAST) begin
            r_cnt    <= '0;
            r_duty_l <= w_duty_l_nx;
            r_duty_r <= w_duty_r_nx;
            r_dir_l  <= w_dir_l_nx;
            r_dir_r  <= w_dir_r_nx;
         end else begin
            r_cnt <= r_cnt + DW'(1);
         end
      end
   end

   assign bus.o_left_pwm  = r_pwm_l;
   assign bus.o_right_pwm = r_pwm_r;
   assign bus.o_left_dir  = r_dir_l;
   assign bus.o_right_dir = r_dir_r;
   assign bus.o_mode      = r_mode;

endmodule

// File: tb/tb_track_drive.sv
// Bench for track_drive: a behavioural model (sample history, mode rules,
// per-period duty arithmetic) is compared with the DUT on every cycle, plus
// directed scenarios with hand-computed expectations and a random phase.
module tb_track_drive;

   localparam int P       = 16;
   localparam int STEP    = 4;
   localparam int FL      = 4;
   localparam int CRUISE  = 12;
   localparam int FAST    = 12;
   localparam int SLOW    = 4;
   localparam int SRCH    = 8;
   localparam int TIMEOUT = 100;

   localparam int MD_IDLE = 0, MD_STRAIGHT = 1, MD_LEFT = 2, MD_RIGHT = 3,
                  MD_SEARCH = 4, MD_STOP = 5;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   track_drive_if bus ();

   track_drive #(
      .PWM_PERIOD    (P),
      .CRUISE_DUTY   (CRUISE),
      .TURN_FAST     (FAST),
      .TURN_SLOW     (SLOW),
      .SEARCH_DUTY   (SRCH),
      .RAMP_STEP     (STEP),
      .FILTER_LEN    (FL),
      .SEARCH_TIMEOUT(TIMEOUT)
   ) dut (
      .i_clk  (clk),
      .i_reset(rst),
      .bus    (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic count_high(output int l, output int r);
      l = 0;
      r = 0;
      repeat (P) begin
         @(negedge clk);
         l += int'(bus.o_left_pwm);
         r += int'(bus.o_right_pwm);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_filt, m_mode, m_stime, m_last_left, m_cnt;
   int m_duty[2];
   int m_dir[2];
   int m_pwm[2];
   int hist[$];

   function automatic int target_of(input int mode, input int w);
      case (mode)
         MD_STRAIGHT: return CRUISE;
         MD_LEFT:     return (w == 0) ? SLOW : FAST;
         MD_RIGHT:    return (w == 0) ? FAST : SLOW;
         MD_SEARCH:   return SRCH;
         default:     return 0;
      endcase
   endfunction

   function automatic int want_of(input int mode, input int last_left, input int w);
      if (mode != MD_SEARCH) return 1;
      // pivot toward the last turn: that side's wheel runs backwards
      if (last_left != 0) return (w == 0) ? 0 : 1;
      return (w == 0) ? 1 : 0;
   endfunction

   task automatic model_reset();
      m_filt = 0; m_mode = MD_IDLE; m_stime = 0; m_last_left = 1; m_cnt = 0;
      for (int w = 0; w < 2; w++) begin
         m_duty[w] = 0; m_dir[w] = 1; m_pwm[w] = 0;
      end
      hist.delete();
   endtask

   task automatic model_edge();
      int tgt, want, diff, nm, same;
      // PWM output is the comparison seen before this edge
      for (int w = 0; w < 2; w++) m_pwm[w] = (m_cnt < m_duty[w]) ? 1 : 0;
      // once per period: drain-and-reverse, or approach the target
      if (m_cnt == P - 1) begin
         for (int w = 0; w < 2; w++) begin
            tgt  = target_of(m_mode, w);
            want = want_of(m_mode, m_last_left, w);
            if (want != m_dir[w]) begin
               if (m_duty[w] == 0) m_dir[w] = want;
               else m_duty[w] = (m_duty[w] > STEP) ? m_duty[w] - STEP : 0;
            end else begin
               diff = tgt - m_duty[w];
               if (diff > STEP)  diff = STEP;
               if (diff < -STEP) diff = -STEP;
               m_duty[w] += diff;
            end
         end
      end
      m_cnt = (m_cnt + 1) % P;
      // mode from the filtered code held before this edge
      if (bus.i_enable !== 1'b1)  nm = MD_IDLE;
      else if (m_filt == 3)       nm = MD_STRAIGHT;
      else if (m_filt == 2)       nm = MD_LEFT;
      else if (m_filt == 1)       nm = MD_RIGHT;
      else if (m_mode == MD_SEARCH) begin
         m_stime++;
         nm = (m_stime >= TIMEOUT) ? MD_STOP : MD_SEARCH;
      end else if (m_mode == MD_STOP) nm = MD_STOP;
      else begin
         nm = MD_SEARCH;
         m_stime = 0;
      end
      m_mode = nm;
      if (nm == MD_LEFT)  m_last_left = 1;
      if (nm == MD_RIGHT) m_last_left = 0;
      // filter: accept when the last FL samples all agree
      hist.push_back(int'(bus.i_state));
      if (hist.size() > FL) void'(hist.pop_front());
      if (hist.size() == FL) begin
         same = 1;
         for (int i = 1; i < FL; i++) if (hist[i] != hist[0]) same = 0;
         if (same != 0) m_filt = hist[0];
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else model_edge();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            check("cyc_mode",      int'(bus.o_mode),      m_mode);
            check("cyc_left_pwm",  int'(bus.o_left_pwm),  m_pwm[0]);
            check("cyc_right_pwm", int'(bus.o_right_pwm), m_pwm[1]);
            check("cyc_left_dir",  int'(bus.o_left_dir),  m_dir[0]);
            check("cyc_right_dir", int'(bus.o_right_dir), m_dir[1]);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int l, r, t, t0, hold;
      rst = 1'b1;
      bus.i_enable = 1'b1;
      bus.i_state  = 2'b11;
      step(3);
      check("reset_mode",  int'(bus.o_mode), 0);
      check("reset_pwm_l", int'(bus.o_left_pwm), 0);
      check("reset_dir_l", int'(bus.o_left_dir), 1);
      check("reset_dir_r", int'(bus.o_right_dir), 1);
      rst = 1'b0;

      // startup ramp
      step(4);
      check("startup_not_yet_straight", int'(bus.o_mode == 3'd1), 0);
      step(1);
      check("startup_mode_straight", int'(bus.o_mode), 1);
      step(80);
      count_high(l, r);
      check("startup_left_high", l, 12);
      check("startup_right_high", r, 12);

      // glitch rejection
      bus.i_state = 2'b10;
      step(3);
      bus.i_state = 2'b11;
      step(10);
      check("glitch_mode", int'(bus.o_mode), 1);
      count_high(l, r);
      check("glitch_left_high", l, 12);

      // left turn
      bus.i_state = 2'b10;
      step(5);
      check("left_mode", int'(bus.o_mode), 2);
      step(64);
      count_high(l, r);
      check("left_left_high", l, 4);
      check("left_right_high", r, 12);
      check("left_dirs", int'({bus.o_left_dir, bus.o_right_dir}), 3);

      // lost line: pivot left, left wheel reverses after draining
      bus.i_state = 2'b00;
      t = 0;
      while (bus.o_mode != 3'd4 && t < 20) begin
         step(1);
         t++;
      end
      check("search_entered", int'(bus.o_mode), 4);
      t0 = cyc;
      step(66);
      count_high(l, r);
      check("search_left_dir", int'(bus.o_left_dir), 0);
      check("search_right_dir", int'(bus.o_right_dir), 1);
      check("search_left_high", l, 8);
      check("search_right_high", r, 8);

      // search timeout
      t = 0;
      while (bus.o_mode != 3'd5 && t < 300) begin
         step(1);
         t++;
      end
      check("timeout_mode", int'(bus.o_mode), 5);
      check("timeout_len", cyc - t0, TIMEOUT);
      step(80);
      count_high(l, r);
      check("stop_left_high", l, 0);
      check("stop_right_high", r, 0);
      bus.i_state = 2'b11;
      step(5);
      check("stop_to_straight", int'(bus.o_mode), 1);

      // enable drop, then ramp down
      step(80);
      bus.i_enable = 1'b0;
      step(1);
      check("enable_drop_mode", int'(bus.o_mode), 0);
      count_high(l, r);
      check("enable_drop_not_cut", int'(l > 0), 1);
      step(64);
      count_high(l, r);
      check("enable_drop_left_high", l, 0);

      // asynchronous reset mid-period
      bus.i_enable = 1'b1;
      step(80);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_pwm_l", int'(bus.o_left_pwm), 0);
      check("async_rst_pwm_r", int'(bus.o_right_pwm), 0);
      check("async_rst_dirs",  int'({bus.o_left_dir, bus.o_right_dir}), 3);
      check("async_rst_mode",  int'(bus.o_mode), 0);
      step(2);
      rst = 1'b0;

      // random phase: model compare does the checking
      for (int k = 0; k < 120; k++) begin
         bus.i_state  = 2'($urandom_range(0, 3));
         bus.i_enable = ($urandom_range(0, 7) != 0);
         hold = ($urandom_range(0, 7) == 0) ? $urandom_range(100, 160)
                                            : $urandom_range(1, 30);
         step(hold);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
